// File: rtl/data_mem_responder_if.sv
// MEM-stage data-memory bus: pipeline (master) issues read/write requests,
// responder (slave) answers with ready, rdata and err.
interface data_mem_responder_if;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    // Handshake: a request (mem_r_en|mem_w_en) is held stable by the master until it
    // sees ready=1; ready=0 means the pipeline must freeze, and ready=1 in the
    // completion cycle qualifies rdata/err. Dropping the request before that aborts it.
    modport master (
        output mem_r_en, mem_w_en, addr, wdata,
        input  rdata, ready, err
    );

    modport slave (
        input  mem_r_en, mem_w_en, addr, wdata,
        output rdata, ready, err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage (IDLE/BUSY/DONE FSM).
// Optional macro DATA_MEM_RESPONDER_STATS_EN adds rd_count/wr_count ports.
module data_mem_responder #(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 3,
    parameter int unsigned BASE_ADDR   = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus,
    output logic [1:0]           o_dbg_state
`ifdef DATA_MEM_RESPONDER_STATS_EN
    ,
    output logic [15:0]          rd_count,
    output logic [15:0]          wr_count
`endif
);
    localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] BASE      = 32'(BASE_ADDR);
    localparam logic [31:0] DEPTH_32  = 32'(DEPTH);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH];

    logic        w_req;
    logic        w_ready;
    logic [31:0] w_offset;
    logic [31:0] w_word;
    logic        w_in_range;
    logic [IDX_W-1:0] w_index;

    assign w_req      = bus.mem_r_en | bus.mem_w_en;
    // Unsigned subtract; addresses below BASE are rejected explicitly, not wrapped.
    assign w_offset   = bus.addr - BASE;
    assign w_word     = w_offset >> 2;
    assign w_in_range = (bus.addr >= BASE) && (w_word < DEPTH_32);
    assign w_index    = w_word[IDX_W-1:0];

    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = ~w_req;
                if (w_req) w_next_state = S_BUSY;
            end
            S_BUSY: begin
                if (!w_req)           w_next_state = S_IDLE;
                else if (r_cnt == '0) w_next_state = S_DONE;
            end
            S_DONE: begin
                w_ready      = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
        end else begin
            r_state <= w_next_state;
            r_err   <= 1'b0;
            if (r_state == S_IDLE && w_req) begin
                r_cnt <= WAIT_INIT;
            end else if (r_state == S_BUSY && w_req) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 4'd1;
                end else begin
                    // A conflicting request is served as a write only.
                    if (bus.mem_w_en) begin
                        if (w_in_range) r_mem[w_index] <= bus.wdata;
                    end else begin
                        r_rdata <= w_in_range ? r_mem[w_index] : '0;
                    end
                    r_err <= ~w_in_range | (bus.mem_r_en & bus.mem_w_en);
                end
            end
        end
    end

`ifdef DATA_MEM_RESPONDER_STATS_EN
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else if (r_state == S_BUSY && w_next_state == S_DONE) begin
            if (bus.mem_w_en) r_wr_count <= r_wr_count + 16'd1;
            else              r_rd_count <= r_rd_count + 16'd1;
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`endif

    assign bus.ready   = w_ready;
    assign bus.rdata   = r_rdata;
    assign bus.err     = r_err;
    assign o_dbg_state = r_state;
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the MEM-stage data-memory interface.
- Accepts one read or write request from the pipeline's MEM stage and serves it from an internal word array after a programmable number of wait states.
- Drives `ready` low while the access is in progress, so the pipeline uses `ready` as its freeze source.
- Replaces the zero-latency combinational data memory, giving the hazard/freeze path a real multi-cycle responder.

Parameters:
- DEPTH, 64, number of 32-bit words in the array (power of 2, 2..1024).
- WAIT_CYCLES, 3, wait states per access (1..15).
- BASE_ADDR, 1024, byte address mapped to word 0.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset.
- mem_r_en  input  1  read request from MEM stage; held stable until `ready`.
- mem_w_en  input  1  write request from MEM stage; held stable until `ready`.
- addr  input  32  byte address (ALU result).
- wdata  input  32  write data (Val_Rm).
- rdata  output  32  read data; valid while ready=1 in DONE after a read.
- ready  output  1  0 = request pending or in progress (pipeline must freeze).
- err  output  1  one-cycle pulse on an out-of-range or conflicting request.

Behaviour:
- Reset (rst=0 at a rising edge):
  - state=IDLE, wait counter=0, rdata=0, err=0.
  - All array words cleared to 0.
  - `ready` is 1 immediately after reset.
  - Reset mid-access aborts the access: no array write occurs.
- Address mapping:
  - word index = (addr - BASE_ADDR) >> 2.
  - addr[1:0] are ignored.
  - In range iff addr >= BASE_ADDR and the index < DEPTH.
  - Subtraction is 32-bit unsigned; addr < BASE_ADDR is out of range, not a wrap-around.
- `req` = mem_r_en | mem_w_en.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - ready = ~req (combinational), so freeze asserts in the same cycle the request appears.
  - On an edge with req=1: go to BUSY, counter = WAIT_CYCLES-1.
- BUSY:
  - ready=0.
  - Each edge with counter != 0: decrement the counter.
  - Edge with counter == 0: perform the access and go to DONE.
    - Write: array[index] <= wdata.
    - Read: rdata <= array[index].
  - Edge with req=0 (request withdrawn, e.g. flush): abort to IDLE with no array write and rdata unchanged.
- DONE:
  - ready=1 for exactly one cycle.
  - Next edge goes to IDLE unconditionally; a request still held then is treated as new.
- Latency: request first seen in cycle 0 -> ready low in cycles 0..WAIT_CYCLES -> ready high in cycle WAIT_CYCLES+1.
- Out-of-range request:
  - Full wait-state timing is preserved.
  - Write is dropped; read returns 0.
  - err pulses for one cycle in DONE.
- Both mem_r_en and mem_w_en high:
  - Treated as a write; the read is suppressed.
  - err pulses in DONE.
- rdata holds its last value outside a completed read; writes never change rdata.
- Back-to-back requests: minimum spacing is WAIT_CYCLES+2 cycles (DONE returns to IDLE before sampling).

Optional Feature:
- Macro: DATA_MEM_RESPONDER_STATS_EN.
- Defined:
  - Adds output ports rd_count[15:0] and wr_count[15:0].
  - Each increments on entry to DONE for a completed read or write, including out-of-range requests.
  - Counters wrap at 16'hFFFF -> 0 and are cleared by rst.
  - Aborted accesses are not counted.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Write then read, WAIT_CYCLES=3:
  - Write addr=1024, wdata=32'hDEADBEEF -> ready low cycles 0..3, high cycle 4, err=0.
  - Read addr=1024 -> rdata=32'hDEADBEEF in the ready cycle.
- Address mapping, ignored low bits, and boundary:
  - Write addr=1024+4*63+2 with data 32'h5A5A5A5A, read addr=1024+252 -> 32'h5A5A5A5A (word 63).
  - Read addr=1024+256 -> rdata=0, err pulse.
  - Read addr=1020 -> rdata=0, err pulse.
- Conflicting request: mem_r_en=mem_w_en=1, addr=1028, wdata=32'h1 -> word 1 becomes 1, rdata unchanged, err pulse in DONE.
- Withdrawal: start a write to 1032 with 32'hFFFF, drop req in cycle 2 -> FSM returns to IDLE, ready=1; a later read of 1032 returns 0.
- Reset mid-access: assert rst=0 in cycle 2 of a write -> next cycle state=IDLE, ready=1, rdata=0; a later read returns 0.
- With DATA_MEM_RESPONDER_STATS_EN: 3 writes + 2 reads (one out of range) -> wr_count=3, rd_count=2; preload wr_count=16'hFFFF via 65535 writes, one more write -> wr_count=0.
